// File: rtl/bcd_cnt_pkg.sv
// Shared digit type and load clamp helper for the packed-digit up/down counter.
package bcd_cnt_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;

  function automatic digit_t clamp_digit(input digit_t d, input int modulus);
    if (int'(d) >= modulus) return digit_t'(modulus - 1);
    return d;
  endfunction
endpackage

// File: rtl/bcd_counter_digit.sv
// One radix-MODULUS digit: load (clamped) > clear > step up > step down > hold.
import bcd_cnt_pkg::*;

module bcd_counter_digit #(
  parameter int MODULUS = 10
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   step_up,
  input  logic   step_dn,
  input  logic   load,
  input  logic   clear,
  input  digit_t load_digit,
  output digit_t digit,
  output logic   at_max,
  output logic   at_zero
);
  localparam digit_t MAX_D = digit_t'(MODULUS - 1);

  digit_t r_digit;

  assign digit   = r_digit;
  assign at_max  = (r_digit == MAX_D);
  assign at_zero = (r_digit == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_digit <= '0;
    else if (load)    r_digit <= clamp_digit(load_digit, MODULUS);
    else if (clear)   r_digit <= '0;
    else if (step_up) r_digit <= at_max  ? '0    : r_digit + 1'b1;
    else if (step_dn) r_digit <= at_zero ? MAX_D : r_digit - 1'b1;
  end
endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit radix-N up/down counter with load clamp, clear, cascade tc and load_err.
// Optional registered compare output enabled by defining BCD_CNT_MATCH_EN.
import bcd_cnt_pkg::*;

module bcd_updown_counter #(
  parameter int DIGITS    = 4,
  parameter int MODULUS   = 10,
  parameter int DOWN_WRAP = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load_n,
  input  logic                  clear_n,
  input  logic                  updown,
`ifdef BCD_CNT_MATCH_EN
  input  logic [4*DIGITS-1:0]   match_value,
  output logic                  match,
`endif
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tc,
  output logic                  load_err
);
  logic [DIGITS-1:0][DIGIT_W-1:0] w_ld, w_digits;
  logic [DIGITS:0]                w_lmax, w_lzero;
  logic [DIGITS-1:0]              w_at_max, w_at_zero, w_bad;
  logic                           w_cnt_en, w_dn_hold;
  logic                           r_load_err;

  assign w_ld      = load_data;
  assign w_cnt_en  = enable & load_n & clear_n;
  // Down count at all-zero freezes every digit unless wrap is configured.
  assign w_dn_hold = (DOWN_WRAP == 0) & w_lzero[DIGITS];
  assign w_lmax[0]  = 1'b1;
  assign w_lzero[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_lmax[g+1]  = w_lmax[g]  & w_at_max[g];
    assign w_lzero[g+1] = w_lzero[g] & w_at_zero[g];
    assign w_bad[g]     = ({1'b0, w_ld[g]} >= 5'(MODULUS));

    bcd_counter_digit #(.MODULUS(MODULUS)) u_dig (
      .clock      (clock),
      .reset_n    (reset_n),
      .step_up    (w_cnt_en & updown & w_lmax[g]),
      .step_dn    (w_cnt_en & ~updown & w_lzero[g] & ~w_dn_hold),
      .load       (~load_n),
      .clear      (~clear_n),
      .load_digit (w_ld[g]),
      .digit      (w_digits[g]),
      .at_max     (w_at_max[g]),
      .at_zero    (w_at_zero[g])
    );
  end

  assign out      = w_digits;
  assign tc       = w_cnt_en & (updown ? w_lmax[DIGITS] : w_lzero[DIGITS]);
  assign load_err = r_load_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_load_err <= 1'b0;
    else          r_load_err <= ~load_n & (|w_bad);
  end

`ifdef BCD_CNT_MATCH_EN
  logic r_match;
  assign match = r_match;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_match <= 1'b0;
    else          r_match <= (out == match_value);
  end
`endif
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: two instances (hold vs wrap on down) checked against
// an integer-valued reference model; optional match port covered when BCD_CNT_MATCH_EN is set.
module tb_bcd_updown_counter;
  localparam int D = 4, M = 10, NMAX = 10000;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        enable = 0, load_n = 1, clear_n = 1, updown = 1;
  logic [15:0] load_data = '0;
  logic [15:0] out0, out1;
  logic        tc0, tc1, le0, le1;
`ifdef BCD_CNT_MATCH_EN
  logic [15:0] match_value = 16'h0005;
  logic        m0, m1;
  logic        exp_m [2];
`endif

  int total = 0, bad = 0;
  int mval [2];
  int wrap [2] = '{0, 1};
  logic exp_le;

  always #5 clock = ~clock;

  bcd_updown_counter #(.DIGITS(D), .MODULUS(M), .DOWN_WRAP(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load_n(load_n),
    .clear_n(clear_n), .updown(updown),
`ifdef BCD_CNT_MATCH_EN
    .match_value(match_value), .match(m0),
`endif
    .load_data(load_data), .out(out0), .tc(tc0), .load_err(le0));

  bcd_updown_counter #(.DIGITS(D), .MODULUS(M), .DOWN_WRAP(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load_n(load_n),
    .clear_n(clear_n), .updown(updown),
`ifdef BCD_CNT_MATCH_EN
    .match_value(match_value), .match(m1),
`endif
    .load_data(load_data), .out(out1), .tc(tc1), .load_err(le1));

  function automatic int to_val(input logic [15:0] p);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * M + int'(p[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] to_pk(input int v);
    logic [15:0] p = '0;
    for (int i = 0; i < D; i++) begin
      p[4*i +: 4] = 4'(v % M);
      v = v / M;
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out0"}, out0, to_pk(mval[0]));
    chk({tag, ".out1"}, out1, to_pk(mval[1]));
    chk({tag, ".le0"}, 16'(le0), 16'(exp_le));
    chk({tag, ".le1"}, 16'(le1), 16'(exp_le));
`ifdef BCD_CNT_MATCH_EN
    chk({tag, ".m0"}, 16'(m0), 16'(exp_m[0]));
    chk({tag, ".m1"}, 16'(m1), 16'(exp_m[1]));
`endif
  endtask

  // One clock: drive, check combinational tc, clock, advance model, check registers.
  task automatic cyc(input string tag, input logic en, input logic ldn, input logic clrn,
                     input logic ud, input logic [15:0] data);
    logic [15:0] cl;
    logic        any_bad;
    enable = en; load_n = ldn; clear_n = clrn; updown = ud; load_data = data;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic etc;
      etc = en & ldn & clrn & (ud ? (mval[k] == NMAX - 1) : (mval[k] == 0));
      chk($sformatf("%s.tc%0d", tag, k), 16'(k == 0 ? tc0 : tc1), 16'(etc));
    end
    @(posedge clock);
    any_bad = 1'b0;
    cl = data;
    for (int i = 0; i < D; i++)
      if (int'(data[4*i +: 4]) >= M) begin
        cl[4*i +: 4] = 4'(M - 1);
        any_bad = 1'b1;
      end
    exp_le = !ldn && any_bad;
    for (int k = 0; k < 2; k++) begin
`ifdef BCD_CNT_MATCH_EN
      exp_m[k] = (to_pk(mval[k]) == match_value);
`endif
      if (!ldn)       mval[k] = to_val(cl);
      else if (!clrn) mval[k] = 0;
      else if (en) begin
        if (ud)              mval[k] = (mval[k] + 1) % NMAX;
        else if (mval[k] > 0) mval[k] = mval[k] - 1;
        else                 mval[k] = wrap[k] ? NMAX - 1 : 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    mval[0] = 0; mval[1] = 0; exp_le = 1'b0;
`ifdef BCD_CNT_MATCH_EN
    exp_m[0] = 1'b0; exp_m[1] = 1'b0;
`endif
    #3;
    check_all("reset");
    #9 reset_n = 1'b1;

    cyc("ld0999", 0, 0, 1, 1, 16'h0999);
    cyc("up_ripple", 1, 1, 1, 1, 16'h0000);
    chk("up_ripple_const", out0, 16'h1000);
    cyc("ld9999", 0, 0, 1, 1, 16'h9999);
    cyc("up_wrap", 1, 1, 1, 1, 16'h0000);
    chk("up_wrap_const", out0, 16'h0000);
    cyc("ld1000", 0, 0, 1, 1, 16'h1000);
    cyc("dn_ripple", 1, 1, 1, 0, 16'h0000);
    chk("dn_ripple_const", out0, 16'h0999);
    cyc("clr", 1, 1, 0, 0, 16'h0000);
    cyc("dn_zero", 1, 1, 1, 0, 16'h0000);
    chk("dn_hold_const", out0, 16'h0000);
    chk("dn_wrap_const", out1, 16'h9999);
    cyc("ld_clamp", 0, 0, 1, 1, 16'h3C5F);
    chk("clamp_const", out0, 16'h3959);
    chk("clamp_err", 16'(le0), 16'h0001);
    cyc("post_clamp", 0, 1, 1, 1, 16'h0000);
    chk("err_pulse", 16'(le0), 16'h0000);
    cyc("prio", 1, 0, 0, 1, 16'h1234);
    chk("prio_const", out0, 16'h1234);
    cyc("hold", 0, 1, 1, 1, 16'h0000);
    cyc("ld0000", 0, 0, 1, 1, 16'h0000);
    for (int i = 0; i < 7; i++) cyc("up_match", 1, 1, 1, 1, 16'h0000);

    // Asynchronous reset in the middle of a counting cycle.
    cyc("ld0357", 0, 0, 1, 1, 16'h0357);
    cyc("cnt", 1, 1, 1, 1, 16'h0000);
    cyc("ld0357b", 0, 0, 1, 1, 16'h0357);
    enable = 1; load_n = 1; updown = 1;
    #2 reset_n = 1'b0;
    #1;
    mval[0] = 0; mval[1] = 0; exp_le = 1'b0;
`ifdef BCD_CNT_MATCH_EN
    exp_m[0] = 1'b0; exp_m[1] = 1'b0;
`endif
    check_all("async_rst");
    chk("async_rst_const", out0, 16'h0000);
    @(negedge clock) reset_n = 1'b1;
    cyc("resume", 1, 1, 1, 1, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      int r;
      logic ldn, clrn;
      r = int'($urandom_range(0, 99));
      ldn  = !(r < 8);
      clrn = !(r >= 8 && r < 12);
      cyc("rand", ($urandom_range(0, 9) != 0), ldn, clrn, 1'($urandom),
          (r < 4) ? 16'h9999 : (r < 6 ? 16'h0000 : 16'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
